// File: rtl/disp_cap_pkg.sv
// Shared packet definitions for the display packet capture block.
// Optional drop counter is enabled by defining DISP_CAP_DROP_CNT_EN.
package disp_cap_pkg;
  localparam int DISP_PKT_W   = 38;
  localparam int PKT_DATA_LSB = 0;
  localparam int PKT_DATA_MSB = 15;
  localparam int DROP_CNT_W   = 8;

  function automatic logic [PKT_DATA_MSB-PKT_DATA_LSB:0] pkt_data(
    input logic [DISP_PKT_W-1:0] pkt
  );
    return pkt[PKT_DATA_MSB:PKT_DATA_LSB];
  endfunction
endpackage

// File: rtl/disp_packet_capture_debounce.sv
// Button debouncer: 2-flop synchronizer followed by a stability counter.
// RISE pulses in the cycle before LEVEL rises, so a consumer acts on the same edge LEVEL updates.
module disp_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic IN,
  output logic LEVEL,
  output logic RISE
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q, level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ, accept;

  always_comb begin
    differ  = (sync2_q != level_q);
    accept  = differ && (cnt_q == CW'(DEB_CYCLES - 1));
    cnt_d   = '0;
    level_d = level_q;
    if (accept) begin
      level_d = sync2_q;
    end else if (differ) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= IN;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LEVEL = level_q;
  assign RISE  = accept & sync2_q;
endmodule

// File: rtl/disp_packet_capture.sv
// Packet snoop FIFO with a STEP-button-driven hold register feeding the 7-seg display.
// Define DISP_CAP_DROP_CNT_EN to add the saturating DROP_CNT output.
module disp_packet_capture
  import disp_cap_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEB_CYCLES = 16,
  parameter int PKT_W      = DISP_PKT_W
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     PKT_VALID,
  input  logic [PKT_W-1:0]         PKT_IN,
  input  logic                     BTN_STEP,
  input  logic                     BTN_SEL,
  output logic [PKT_W-1:0]         PACKET_OUT,
  output logic                     HOLD_VALID,
  output logic [$clog2(DEPTH):0]   COUNT,
`ifdef DISP_CAP_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]    DROP_CNT,
`endif
  output logic                     OVF
  ,output logic                    DISP_SWITCH
);
  localparam int AW = $clog2(DEPTH);

  logic             step_pulse;
  logic             sel_level;
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PKT_W-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PKT_W-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, pop, wr_en, drop;

  disp_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .CLK(CLK), .nRST(nRST), .IN(BTN_STEP), .LEVEL(), .RISE(step_pulse)
  );

  disp_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .CLK(CLK), .nRST(nRST), .IN(BTN_SEL), .LEVEL(sel_level), .RISE()
  );

  // Extra wrap bit: equal pointers mean empty, differing only in MSB means full.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop   = step_pulse && !empty;
    wr_en = PKT_VALID && (!full || pop);
    drop  = PKT_VALID && full && !pop;
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    ovf_d        = ovf_q | drop;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = PKT_IN;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      hold_d       = mem_q[rd_ptr_q[AW-1:0]];
      hold_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef DISP_CAP_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign DROP_CNT = drop_cnt_q;
`endif

  assign PACKET_OUT  = hold_q;
  assign HOLD_VALID  = hold_valid_q;
  assign COUNT       = wr_ptr_q - rd_ptr_q;
  assign OVF         = ovf_q;
  assign DISP_SWITCH = sel_level;
endmodule
